// File: rtl/sdf_bf_stage.sv
// Radix-2 SDF butterfly stage: pairs samples DEPTH apart, emits y0 and recirculates y1.
// Optional drain input enabled by defining BF_STAGE_FLUSH_EN.
module sdf_bf_lane #(
  parameter int WIDTH = 16,
  parameter int RH    = 0
) (
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1
);
  logic [WIDTH:0] s, d;

  // One guard bit keeps the sum/difference exact; the halving drops it back to WIDTH.
  assign s  = {x0[WIDTH-1], x0} + {x1[WIDTH-1], x1} + (WIDTH+1)'(RH);
  assign d  = {x0[WIDTH-1], x0} - {x1[WIDTH-1], x1} + (WIDTH+1)'(RH);
  assign y0 = s[WIDTH:1];
  assign y1 = d[WIDTH:1];
endmodule

module sdf_bf_stage #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int RH    = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    di_en,
  input  logic signed [WIDTH-1:0] di_re,
  input  logic signed [WIDTH-1:0] di_im,
`ifdef BF_STAGE_FLUSH_EN
  input  logic                    flush,
`endif
  output logic                    do_en,
  output logic signed [WIDTH-1:0] do_re,
  output logic signed [WIDTH-1:0] do_im
);
  localparam int CW = $clog2(2*DEPTH);

  logic [CW-1:0]                  cnt;
  logic                           bf_en, primed, adv, flush_go;
  logic [1:0][WIDTH-1:0]          di_c, dl_in, dl_out, y0, y1, cand;
  logic [DEPTH-1:0][1:0][WIDTH-1:0] dl;

  assign bf_en = cnt[CW-1];

`ifdef BF_STAGE_FLUSH_EN
  // Drain pending y1 values by feeding zeros through the first half.
  assign flush_go = flush & ~di_en & primed & ~bf_en;
`else
  assign flush_go = 1'b0;
`endif

  assign adv    = di_en | flush_go;
  assign di_c   = flush_go ? '0 : {di_im, di_re};
  assign dl_out = dl[DEPTH-1];
  assign dl_in  = bf_en ? y1 : di_c;
  assign cand   = bf_en ? y0 : dl_out;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    sdf_bf_lane #(.WIDTH(WIDTH), .RH(RH)) u_lane (
      .x0 (dl_out[g]),
      .x1 (di_c[g]),
      .y0 (y0[g]),
      .y1 (y1[g])
    );
  end

  // Delay line carries no reset; primed keeps stale contents from being emitted.
  always_ff @(posedge clock) begin
    if (adv) dl <= {dl[DEPTH-2:0], dl_in};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      primed <= 1'b0;
      do_en  <= 1'b0;
      do_re  <= '0;
      do_im  <= '0;
    end else if (adv) begin
      cnt    <= cnt + 1'b1;
      if (bf_en) primed <= 1'b1;
      do_en  <= primed | bf_en;
      do_re  <= cand[0];
      do_im  <= cand[1];
    end else begin
      do_en  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sdf_bf_stage.sv
// Directed bench for sdf_bf_stage (DEPTH=4): RH=0 and RH=1 instances share one stimulus.
module tb_sdf_bf_stage;
  localparam int W = 16;
  localparam int D = 4;

  logic clock = 1'b0, reset = 1'b0, di_en = 1'b0;
  logic signed [W-1:0] di_re = '0, di_im = '0;
`ifdef BF_STAGE_FLUSH_EN
  logic flush = 1'b0;
`endif
  logic do_en0, do_en1;
  logic signed [W-1:0] do_re0, do_im0, do_re1, do_im1;

  int n_run = 0, n_fail = 0;
  int q_re0[$], q_im0[$], q_re1[$], q_im1[$];
  int e_re[$], e_im[$];

  sdf_bf_stage #(.WIDTH(W), .DEPTH(D), .RH(0)) u_dut0 (
    .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
`ifdef BF_STAGE_FLUSH_EN
    .flush(flush),
`endif
    .do_en(do_en0), .do_re(do_re0), .do_im(do_im0)
  );

  sdf_bf_stage #(.WIDTH(W), .DEPTH(D), .RH(1)) u_dut1 (
    .clock(clock), .reset(reset), .di_en(di_en), .di_re(di_re), .di_im(di_im),
`ifdef BF_STAGE_FLUSH_EN
    .flush(flush),
`endif
    .do_en(do_en1), .do_re(do_re1), .do_im(do_im1)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (do_en0) begin q_re0.push_back(int'(do_re0)); q_im0.push_back(int'(do_im0)); end
    if (do_en1) begin q_re1.push_back(int'(do_re1)); q_im1.push_back(int'(do_im1)); end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic chk_seq(input string tag, input int q[$], input int e[$]);
    chk({tag, "_len"}, q.size(), e.size());
    for (int i = 0; i < e.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), (i < q.size()) ? q[i] : 32'h7fff_dead, e[i]);
  endtask

  task automatic drive(input logic en, input int re, input int im);
    @(negedge clock);
    di_en = en; di_re = W'(re); di_im = W'(im);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b0; di_en = 1'b0; di_re = '0; di_im = '0;
    @(negedge clock);
    chk({tag, "_rst_en"}, int'(do_en0), 0);
    chk({tag, "_rst_re"}, int'(do_re0), 0);
    chk({tag, "_rst_im"}, int'(do_im0), 0);
    @(negedge clock);
    q_re0.delete(); q_im0.delete(); q_re1.delete(); q_im1.delete();
    reset = 1'b1;
  endtask

  // Frame 1..8 then a zero frame: y0 = 3..6, then pending y1 = -2 x4.
  task automatic run_ramp(input string tag);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i, 0);
      if (i == 5) chk({tag, "_first_half_quiet"}, q_re0.size(), 0);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 0, 0);
    idle(2);
    e_re = '{3, 4, 5, 6, -2, -2, -2, -2};
    e_im = '{0, 0, 0, 0, 0, 0, 0, 0};
    chk_seq({tag, "_re"}, q_re0, e_re);
    chk_seq({tag, "_im"}, q_im0, e_im);
  endtask

  initial begin
    // Test 1: basic ramp
    do_reset("t1");
    run_ramp("t1");

    // Test 2: extremes on re, rounding on im (x0 = 1, x1 = 2)
    do_reset("t2");
    begin
      int xr[8] = '{-32768, 32767, 32767, 0, -32768, 32767, -32768, 0};
      int xi[8] = '{1, 0, 0, 0, 2, 0, 0, 0};
      for (int i = 0; i < 8; i++) drive(1'b1, xr[i], xi[i]);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 0, 0);
    idle(2);
    e_re = '{-32768, 32767, -1, 0, 0, 0, 32767, 0};
    chk_seq("t2_ext_re", q_re0, e_re);
    e_im = '{1, 0, 0, 0, -1, 0, 0, 0};
    chk_seq("t2_rnd_rh0", q_im0, e_im);
    e_im = '{2, 0, 0, 0, 0, 0, 0, 0};
    chk_seq("t2_rnd_rh1", q_im1, e_im);

    // Test 3: random di_en gaps over three frames
    do_reset("t3");
    for (int i = 1; i <= 24; i++) begin
      while ($urandom_range(1, 0) == 1) drive(1'b0, 0, 0);
      drive(1'b1, i, -i);
    end
    idle(3);
    e_re.delete(); e_im.delete();
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin e_re.push_back(8*f + 3 + k); e_im.push_back(-(8*f + 3 + k)); end
      if (f < 2) for (int k = 0; k < 4; k++) begin e_re.push_back(-2); e_im.push_back(2); end
    end
    chk_seq("t3_re", q_re0, e_re);
    chk_seq("t3_im", q_im0, e_im);

    // Test 4: async reset at cnt=6, then a clean rerun
    do_reset("t4");
    for (int i = 1; i <= 6; i++) drive(1'b1, i, 0);
    @(negedge clock);
    di_en = 1'b0;
    chk("t4_pre_en", int'(do_en0), 1);
    chk("t4_pre_re", int'(do_re0), 4);
    #2 reset = 1'b0;
    #1;
    chk("t4_async_en", int'(do_en0), 0);
    chk("t4_async_re", int'(do_re0), 0);
    do_reset("t4b");
    run_ramp("t4r");

`ifdef BF_STAGE_FLUSH_EN
    // Test 5: flush drains the pending y1 values, then stops at the second half
    do_reset("t5");
    for (int i = 1; i <= 8; i++) drive(1'b1, i, 0);
    @(negedge clock);
    di_en = 1'b0; flush = 1'b1;
    repeat (8) @(negedge clock);
    flush = 1'b0;
    idle(2);
    e_re = '{3, 4, 5, 6, -2, -2, -2, -2};
    chk_seq("t5_flush", q_re0, e_re);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
